// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: pixel width, 3x3 window indexing and the
// window struct handed to neighbourhood filters.
package img_pkg;

  localparam int DATA_W = 8;

  localparam int TAP_OLD = 0;
  localparam int TAP_MID = 1;
  localparam int TAP_NEW = 2;
  localparam int WIN_TAPS = 3;

  typedef logic [DATA_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t m11, m12, m13;
    pixel_t m21, m22, m23;
    pixel_t m31, m32, m33;
  } window_t;

  // Number of valid lines seen in the frame; saturates once both upper rows are real.
  typedef enum logic [1:0] {
    ROW_FIRST  = 2'd0,
    ROW_SECOND = 2'd1,
    ROW_FULL   = 2'd2
  } row_state_e;

endpackage

// File: rtl/matrix_3x3_gen_if.sv
// Pixel stream in, 3x3 window out; the generator sits on the slave side.
interface matrix_3x3_gen_if #(
  parameter int DATA_W = 8
);

  logic              per_vs;
  logic              per_de;
  logic [DATA_W-1:0] per_data;

  logic              matrix_vs;
  logic              matrix_de;
  logic [DATA_W-1:0] matrix11, matrix12, matrix13;
  logic [DATA_W-1:0] matrix21, matrix22, matrix23;
  logic [DATA_W-1:0] matrix31, matrix32, matrix33;

  modport master (
    output per_vs, per_de, per_data,
    input  matrix_vs, matrix_de,
    input  matrix11, matrix12, matrix13,
    input  matrix21, matrix22, matrix23,
    input  matrix31, matrix32, matrix33
  );

  modport slave (
    input  per_vs, per_de, per_data,
    output matrix_vs, matrix_de,
    output matrix11, matrix12, matrix13,
    output matrix21, matrix22, matrix23,
    output matrix31, matrix32, matrix33
  );

endinterface

// File: rtl/line_buf_ram.sv
// Simple dual-port line buffer, synchronous read, read-first on address collision.
// Kept as its own module so a vendor RAM primitive can replace it.
module line_buf_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood generator: two buffered lines plus the live line feed three
// 3-tap shift registers; every output is exactly two cycles behind its input.
module matrix_3x3_gen
  import img_pkg::*;
#(
  parameter int H_MAX  = 1024,
  parameter int DATA_W = img_pkg::DATA_W
) (
  input  logic             video_clk,
  input  logic             rst_n,
  matrix_3x3_gen_if.slave  bus
);

  localparam int ADDR_W = $clog2(H_MAX);
  localparam int COL_W  = ADDR_W + 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_MAX);

  logic [COL_W-1:0]    col;
  row_state_e          row_cnt;
  logic                in_range;
  logic [ADDR_W-1:0]   rd_addr;

  logic                vs_d1, de_d1, hit_d1;
  row_state_e          row_d1;
  logic [DATA_W-1:0]   pix_d1;
  logic [ADDR_W-1:0]   addr_d1;

  logic [2*DATA_W-1:0] line_q;
  logic [2*DATA_W-1:0] wr_data;
  logic [DATA_W-1:0]   top_new, mid_new;

  logic                vs_d2, de_d2, line_start;
  logic [DATA_W-1:0]   top_sr [WIN_TAPS];
  logic [DATA_W-1:0]   mid_sr [WIN_TAPS];
  logic [DATA_W-1:0]   bot_sr [WIN_TAPS];

  assign in_range = bus.per_de && (col < COL_MAX);
  assign rd_addr  = col[ADDR_W-1:0];

  // Counters and the first pipeline stage (pixel, flags, address, row state).
  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      col     <= '0;
      row_cnt <= ROW_FIRST;
      vs_d1   <= 1'b0;
      de_d1   <= 1'b0;
      hit_d1  <= 1'b0;
      row_d1  <= ROW_FIRST;
      pix_d1  <= '0;
      addr_d1 <= '0;
    end else begin
      vs_d1   <= bus.per_vs;
      de_d1   <= bus.per_de;
      hit_d1  <= in_range;
      row_d1  <= row_cnt;
      pix_d1  <= bus.per_data;
      addr_d1 <= rd_addr;

      if (!bus.per_de)         col <= '0;
      else if (col != COL_MAX) col <= col + COL_W'(1);

      if (bus.per_vs && !vs_d1) begin
        row_cnt <= ROW_FIRST;
      end else if (!bus.per_de && de_d1) begin
        case (row_cnt)
          ROW_FIRST:  row_cnt <= ROW_SECOND;
          default:    row_cnt <= ROW_FULL;
        endcase
      end
    end
  end

  // The old line n-1 field only exists once the sync read returns, so the
  // shifted entry is written back one cycle later at the same address.
  assign wr_data = {line_q[DATA_W-1:0], pix_d1};

  line_buf_ram #(
    .DEPTH (H_MAX),
    .WIDTH (2*DATA_W)
  ) u_line_buf (
    .clk     (video_clk),
    .wr_en   (hit_d1),
    .wr_addr (addr_d1),
    .wr_data (wr_data),
    .rd_en   (in_range),
    .rd_addr (rd_addr),
    .rd_data (line_q)
  );

  assign top_new    = (hit_d1 && row_d1 == ROW_FULL)  ? line_q[2*DATA_W-1:DATA_W] : '0;
  assign mid_new    = (hit_d1 && row_d1 != ROW_FIRST) ? line_q[DATA_W-1:0]        : '0;
  assign line_start = de_d1 && !de_d2;

  // Window shift; older columns restart from zero at each line start, and the
  // window holds its last value through blanking.
  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      vs_d2 <= 1'b0;
      de_d2 <= 1'b0;
      for (int i = 0; i < WIN_TAPS; i++) begin
        top_sr[i] <= '0;
        mid_sr[i] <= '0;
        bot_sr[i] <= '0;
      end
    end else begin
      vs_d2 <= vs_d1;
      de_d2 <= de_d1;
      if (de_d1) begin
        top_sr[TAP_NEW] <= top_new;
        mid_sr[TAP_NEW] <= mid_new;
        bot_sr[TAP_NEW] <= pix_d1;
        top_sr[TAP_MID] <= line_start ? '0 : top_sr[TAP_NEW];
        mid_sr[TAP_MID] <= line_start ? '0 : mid_sr[TAP_NEW];
        bot_sr[TAP_MID] <= line_start ? '0 : bot_sr[TAP_NEW];
        top_sr[TAP_OLD] <= line_start ? '0 : top_sr[TAP_MID];
        mid_sr[TAP_OLD] <= line_start ? '0 : mid_sr[TAP_MID];
        bot_sr[TAP_OLD] <= line_start ? '0 : bot_sr[TAP_MID];
      end
    end
  end

  assign bus.matrix_vs = vs_d2;
  assign bus.matrix_de = de_d2;
  assign bus.matrix11  = top_sr[TAP_OLD];
  assign bus.matrix12  = top_sr[TAP_MID];
  assign bus.matrix13  = top_sr[TAP_NEW];
  assign bus.matrix21  = mid_sr[TAP_OLD];
  assign bus.matrix22  = mid_sr[TAP_MID];
  assign bus.matrix23  = mid_sr[TAP_NEW];
  assign bus.matrix31  = bot_sr[TAP_OLD];
  assign bus.matrix32  = bot_sr[TAP_MID];
  assign bus.matrix33  = bot_sr[TAP_NEW];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen with H_MAX=8: captured windows are compared
// against a table of hand-computed neighbourhoods, plus latency/reset sequences.
module tb_matrix_3x3_gen;

  logic video_clk;
  logic rst_n;

  matrix_3x3_gen_if #(.DATA_W(8)) bus ();

  matrix_3x3_gen #(
    .H_MAX  (8),
    .DATA_W (8)
  ) dut (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  typedef struct {
    int          idx;
    string       name;
    logic [71:0] exp;
  } vec_t;

  vec_t        vecs [$];
  logic [71:0] cap  [$];
  int          checks;
  int          failures;

  initial video_clk = 1'b0;
  always #5 video_clk = ~video_clk;

  function automatic logic [71:0] taps_now();
    return {bus.matrix11, bus.matrix12, bus.matrix13,
            bus.matrix21, bus.matrix22, bus.matrix23,
            bus.matrix31, bus.matrix32, bus.matrix33};
  endfunction

  always @(negedge video_clk) begin
    if (rst_n && bus.matrix_de) cap.push_back(taps_now());
  end

  task automatic add_vec(input int idx, input string name,
                         input int a, input int b, input int c,
                         input int d, input int e, input int f,
                         input int g, input int h, input int i);
    vec_t v;
    v.idx  = idx;
    v.name = name;
    v.exp  = {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input logic vs, input logic de, input logic [7:0] d);
    bus.per_vs   = vs;
    bus.per_de   = de;
    bus.per_data = d;
    @(posedge video_clk);
    #1;
  endtask

  task automatic send_line(input int start, input int len);
    for (int c = 0; c < len; c++) apply_stimulus(1'b0, 1'b1, 8'(start + c));
    apply_stimulus(1'b0, 1'b0, 8'd0);
  endtask

  task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_de"},   72'(bus.matrix_de), 72'd0);
    check_output({name, "_vs"},   72'(bus.matrix_vs), 72'd0);
    check_output({name, "_taps"}, taps_now(),         72'd0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.per_vs   = 1'b0;
    bus.per_de   = 1'b0;
    bus.per_data = 8'd0;

    // frame 1: p(r,c) = 16r+c+1, captures 0..15
    add_vec( 0, "f1_r0c0",  0, 0, 0,   0, 0, 0,   0, 0, 1);
    add_vec( 1, "f1_r0c1",  0, 0, 0,   0, 0, 0,   0, 1, 2);
    add_vec( 4, "f1_r1c0",  0, 0, 0,   0, 0, 1,   0, 0,17);
    add_vec( 7, "f1_r1c3",  0, 0, 0,   2, 3, 4,  18,19,20);
    add_vec(10, "f1_r2c2",  1, 2, 3,  17,18,19,  33,34,35);
    add_vec(15, "f1_r3c3", 18,19,20,  34,35,36,  50,51,52);
    // frame 2: p+100, captures 16..31
    add_vec(16, "f2_r0c0",  0, 0, 0,   0, 0, 0,   0, 0,101);
    add_vec(19, "f2_r0c3",  0, 0, 0,   0, 0, 0, 102,103,104);
    add_vec(20, "f2_r1c0",  0, 0, 0,   0, 0,101,  0, 0,117);
    add_vec(26, "f2_r2c2", 101,102,103, 117,118,119, 133,134,135);
    add_vec(31, "f2_r3c3", 118,119,120, 134,135,136, 150,151,152);
    // frame 3: 8-pixel lines with a 10-pixel row 2, captures 32..65
    add_vec(55, "f3_r2c7",  6, 7, 8,  22,23,24,  38,39,40);
    add_vec(56, "f3_r2c8",  7, 8, 0,  23,24, 0,  39,40,41);
    add_vec(57, "f3_r2c9",  8, 0, 0,  24, 0, 0,  40,41,42);
    add_vec(58, "f3_r3c0",  0, 0,17,   0, 0,33,   0, 0,49);
    add_vec(65, "f3_r3c7", 22,23,24,  38,39,40,  54,55,56);
    // frame 4 after mid-line reset, captures 74..81
    add_vec(74, "rst_l0c0", 0, 0, 0,   0, 0, 0,   0, 0,201);
    add_vec(77, "rst_l0c3", 0, 0, 0,   0, 0, 0, 202,203,204);
    add_vec(78, "rst_l1c0", 0, 0, 0,   0, 0,201,  0, 0,221);
    add_vec(81, "rst_l1c3", 0, 0, 0, 202,203,204, 222,223,224);

    repeat (3) apply_stimulus(1'b0, 1'b0, 8'd0);
    @(negedge video_clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) apply_stimulus(1'b0, 1'b0, 8'd0);

    apply_stimulus(1'b1, 1'b0, 8'd0);
    @(negedge video_clk);
    check_output("vs_early", 72'(bus.matrix_vs), 72'd0);
    apply_stimulus(1'b0, 1'b0, 8'd0);
    @(negedge video_clk);
    check_output("vs_latency", 72'(bus.matrix_vs), 72'd1);

    apply_stimulus(1'b0, 1'b1, 8'd1);
    @(negedge video_clk);
    check_output("de_early", 72'(bus.matrix_de), 72'd0);
    apply_stimulus(1'b0, 1'b1, 8'd2);
    @(negedge video_clk);
    check_output("de_latency", 72'(bus.matrix_de), 72'd1);
    check_output("first_m33", 72'(bus.matrix33), 72'd1);
    apply_stimulus(1'b0, 1'b1, 8'd3);
    apply_stimulus(1'b0, 1'b1, 8'd4);
    apply_stimulus(1'b0, 1'b0, 8'd0);
    send_line(17, 4);
    send_line(33, 4);
    send_line(49, 4);
    repeat (3) apply_stimulus(1'b0, 1'b0, 8'd0);

    apply_stimulus(1'b1, 1'b0, 8'd0);
    apply_stimulus(1'b0, 1'b0, 8'd0);
    send_line(101, 4);
    send_line(117, 4);
    send_line(133, 4);
    send_line(149, 4);
    repeat (3) apply_stimulus(1'b0, 1'b0, 8'd0);

    apply_stimulus(1'b1, 1'b0, 8'd0);
    apply_stimulus(1'b0, 1'b0, 8'd0);
    send_line(1, 8);
    send_line(17, 8);
    send_line(33, 10);
    send_line(49, 8);
    repeat (3) apply_stimulus(1'b0, 1'b0, 8'd0);

    apply_stimulus(1'b1, 1'b0, 8'd0);
    apply_stimulus(1'b0, 1'b0, 8'd0);
    send_line(1, 4);
    send_line(17, 4);
    apply_stimulus(1'b0, 1'b1, 8'd33);
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b1, 8'd34);
    rst_n = 1'b1;
    bus.per_de   = 1'b0;
    bus.per_data = 8'd0;
    @(negedge video_clk);
    check_all_zero("mid_reset");
    repeat (2) apply_stimulus(1'b0, 1'b0, 8'd0);
    send_line(201, 4);
    send_line(221, 4);
    repeat (4) apply_stimulus(1'b0, 1'b0, 8'd0);

    check_output("capture_count", 72'(cap.size()), 72'd82);
    foreach (vecs[k]) begin
      if (vecs[k].idx < cap.size()) begin
        check_output(vecs[k].name, cap[vecs[k].idx], vecs[k].exp);
      end else begin
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=missing required=%h", vecs[k].name, vecs[k].exp);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
